// File: rtl/seq_multimode_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter, one bit per clock, ready/valid on both sides.
// Define SEQ_SHIFTER_OVERFLOW_EN to get a sticky LSL sign-change overflow flag.
module seq_multimode_shifter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               carry,
  output logic               zero,
  output logic               negative,
  output logic               overflow
);

  localparam logic [1:0] ModeLsl = 2'b00;
  localparam logic [1:0] ModeLsr = 2'b01;
  localparam logic [1:0] ModeAsr = 2'b10;
  localparam logic [1:0] ModeRor = 2'b11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             r_state;
  logic [1:0]         r_mode;
  logic [SHAMT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_y;
  logic               r_carry;
  logic               r_zero;
  logic               r_negative;
  logic               r_out_valid;

  logic [WIDTH-1:0]   w_y_next;
  logic               w_carry_next;
  logic               w_accept;

  assign w_accept = (r_state == StIdle) && in_valid;

  // One-bit step of the latched operation.
  always_comb begin
    w_y_next     = r_y;
    w_carry_next = r_y[0];
    case (r_mode)
      ModeLsl: begin
        w_y_next     = {r_y[WIDTH-2:0], 1'b0};
        w_carry_next = r_y[WIDTH-1];
      end
      ModeLsr: w_y_next = {1'b0, r_y[WIDTH-1:1]};
      ModeAsr: w_y_next = {r_y[WIDTH-1], r_y[WIDTH-1:1]};
      ModeRor: w_y_next = {r_y[0], r_y[WIDTH-1:1]};
      default: w_y_next = r_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_mode      <= ModeLsl;
      r_count     <= '0;
      r_y         <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_y        <= a;
            r_zero     <= (a == '0);
            r_negative <= a[WIDTH-1];
            r_carry    <= 1'b0;
            r_mode     <= mode;
            r_count    <= shamt;
            if (shamt == '0) begin
              r_state     <= StDone;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= StShift;
            end
          end
        end
        StShift: begin
          r_y        <= w_y_next;
          r_carry    <= w_carry_next;
          r_zero     <= (w_y_next == '0);
          r_negative <= w_y_next[WIDTH-1];
          r_count    <= r_count - SHAMT_W'(1);
          if (r_count == SHAMT_W'(1)) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef SEQ_SHIFTER_OVERFLOW_EN
  logic r_overflow;

  // Sticky: any LSL step that flips the sign bit marks the whole operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_overflow <= 1'b0;
    end else if ((r_state == StShift) && (r_mode == ModeLsl) &&
                 (r_y[WIDTH-1] != r_y[WIDTH-2])) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

  assign in_ready  = (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign negative  = r_negative;

endmodule

// File: tb/tb_seq_multimode_shifter.sv
// Scoreboard bench for seq_multimode_shifter (WIDTH=4, SHAMT_W=3).
module tb_seq_multimode_shifter;

  localparam int W  = 4;
  localparam int SW = 3;
`ifdef SEQ_SHIFTER_OVERFLOW_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [SW-1:0] shamt;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic          carry;
  logic          zero;
  logic          negative;
  logic          overflow;

  seq_multimode_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
    logic [7:0]   lat;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic res_t mk(logic [W-1:0] yv, logic cv, logic vv, int lat);
    res_t r;
    r.y   = yv;
    r.c   = cv;
    r.z   = (yv == '0);
    r.n   = yv[W-1];
    r.v   = vv & OvfEn;
    r.lat = 8'(lat);
    return r;
  endfunction

  function automatic string fmt(res_t r);
    return $sformatf("y=%b c=%b z=%b n=%b v=%b lat=%0d", r.y, r.c, r.z, r.n, r.v, r.lat);
  endfunction

  // Reference: iterate the shift literally, shamt times.
  function automatic res_t model(logic [W-1:0] av, logic [SW-1:0] sv, logic [1:0] mv);
    logic [W-1:0] t = av;
    logic         c = 1'b0;
    logic         v = 1'b0;
    for (int i = 0; i < int'(sv); i++) begin
      case (mv)
        2'b00: begin
          if (t[W-1] != t[W-2]) v = 1'b1;
          c = t[W-1];
          t = t << 1;
        end
        2'b01: begin c = t[0]; t = t >> 1; end
        2'b10: begin c = t[0]; t = {t[W-1], t[W-1:1]}; end
        default: begin c = t[0]; t = {t[0], t[W-1:1]}; end
      endcase
    end
    return mk(t, c, v, (sv == 0) ? 1 : int'(sv) + 1);
  endfunction

  // Issue one request from IDLE; returns at the negedge where out_valid is first seen.
  task automatic do_op(input logic [W-1:0] av, input logic [SW-1:0] sv, input logic [1:0] mv,
                       input res_t e, output res_t obs, output res_t ex);
    int cyc;
    exp_q.push_back(e);
    a = av; shamt = sv; mode = mv; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    cyc = 1;
    while (1) begin
      @(negedge clk);
      if (out_valid === 1'b1 || cyc >= 20) break;
      cyc++;
    end
    obs.y = y; obs.c = carry; obs.z = zero; obs.n = negative; obs.v = overflow;
    obs.lat = 8'(cyc);
    ex = exp_q.pop_front();
  endtask

  task automatic consume();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; shamt = '0; mode = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++;
    if ({in_ready, out_valid, y, carry, zero, negative, overflow} !== 10'b10_0000_0000) begin
      bad++;
      $display("FAIL reset rdy=%b ov=%b y=%b c=%b z=%b n=%b v=%b want rdy=1 rest 0",
               in_ready, out_valid, y, carry, zero, negative, overflow);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_lsl();
    res_t obs, ex;
    do_op(4'b0101, 3'd1, 2'b00, mk(4'b1010, 1'b0, 1'b1, 2), obs, ex);
    total++;
    if (obs !== ex) begin bad++; $display("FAIL lsl_0101 got %s want %s", fmt(obs), fmt(ex)); end
    consume();
    do_op(4'b1111, 3'd2, 2'b00, mk(4'b1100, 1'b1, 1'b0, 3), obs, ex);
    total++;
    if (obs !== ex) begin bad++; $display("FAIL lsl_1111 got %s want %s", fmt(obs), fmt(ex)); end
    consume();
  endtask

  task automatic test_right_shifts();
    res_t obs, ex;
    do_op(4'b1001, 3'd1, 2'b01, mk(4'b0100, 1'b1, 1'b0, 2), obs, ex);
    total++;
    if (obs !== ex) begin bad++; $display("FAIL lsr_1001 got %s want %s", fmt(obs), fmt(ex)); end
    consume();
    do_op(4'b1000, 3'd2, 2'b10, mk(4'b1110, 1'b0, 1'b0, 3), obs, ex);
    total++;
    if (obs !== ex) begin bad++; $display("FAIL asr_1000 got %s want %s", fmt(obs), fmt(ex)); end
    consume();
    do_op(4'b0110, 3'd7, 2'b10, mk(4'b0000, 1'b0, 1'b0, 8), obs, ex);
    total++;
    if (obs !== ex) begin bad++; $display("FAIL asr_0110_7 got %s want %s", fmt(obs), fmt(ex)); end
    consume();
  endtask

  task automatic test_rotate_and_zero();
    res_t obs, ex;
    do_op(4'b0001, 3'd5, 2'b11, mk(4'b1000, 1'b1, 1'b0, 6), obs, ex);
    total++;
    if (obs !== ex) begin bad++; $display("FAIL ror_0001_5 got %s want %s", fmt(obs), fmt(ex)); end
    consume();
    for (int m = 0; m < 4; m++) begin
      do_op(4'b1011, 3'd0, 2'(m), mk(4'b1011, 1'b0, 1'b0, 1), obs, ex);
      total++;
      if (obs !== ex) begin
        bad++; $display("FAIL sh0_mode%0d got %s want %s", m, fmt(obs), fmt(ex));
      end
      consume();
    end
  endtask

  task automatic test_back_pressure();
    res_t obs, ex;
    out_ready = 1'b0;
    do_op(4'b1001, 3'd1, 2'b01, mk(4'b0100, 1'b1, 1'b0, 2), obs, ex);
    total++;
    if (obs !== ex) begin bad++; $display("FAIL bp_result got %s want %s", fmt(obs), fmt(ex)); end
    a = 4'b1111; shamt = 3'd0; mode = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, y, carry, zero, negative, overflow} !==
          {1'b1, 1'b0, ex.y, ex.c, ex.z, ex.n, ex.v}) begin
        bad++;
        $display("FAIL bp_hold[%0d] ov=%b rdy=%b y=%b c=%b z=%b n=%b v=%b want ov=1 rdy=0 %s",
                 i, out_valid, in_ready, y, carry, zero, negative, overflow, fmt(ex));
      end
    end
    // in_valid stays high across the consume edge; it must not be taken.
    out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
        bad++; $display("FAIL bp_release[%0d] ov=%b rdy=%b want ov=0 rdy=1", i, out_valid, in_ready);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid_op();
    res_t obs, ex;
    a = 4'b1010; shamt = 3'd6; mode = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, y, carry, zero, negative, overflow} !== 10'b10_0000_0000) begin
        bad++;
        $display("FAIL rst_mid[%0d] rdy=%b ov=%b y=%b c=%b z=%b n=%b v=%b want rdy=1 rest 0",
                 i, in_ready, out_valid, y, carry, zero, negative, overflow);
      end
    end
    @(posedge clk); #1;
    do_op(4'b0011, 3'd1, 2'b00, mk(4'b0110, 1'b0, 1'b0, 2), obs, ex);
    total++;
    if (obs !== ex) begin bad++; $display("FAIL after_rst got %s want %s", fmt(obs), fmt(ex)); end
    consume();
  endtask

  task automatic test_overflow();
    res_t obs, ex;
    do_op(4'b0100, 3'd1, 2'b00, mk(4'b1000, 1'b0, 1'b1, 2), obs, ex);
    total++;
    if (obs !== ex) begin bad++; $display("FAIL ovf_set got %s want %s", fmt(obs), fmt(ex)); end
    consume();
    do_op(4'b1100, 3'd1, 2'b00, mk(4'b1000, 1'b1, 1'b0, 2), obs, ex);
    total++;
    if (obs !== ex) begin bad++; $display("FAIL ovf_clear got %s want %s", fmt(obs), fmt(ex)); end
    consume();
    do_op(4'b0100, 3'd3, 2'b01, mk(4'b0000, 1'b1, 1'b0, 4), obs, ex);
    total++;
    if (obs !== ex) begin bad++; $display("FAIL ovf_lsr got %s want %s", fmt(obs), fmt(ex)); end
    consume();
  endtask

  task automatic test_random();
    res_t obs, ex;
    logic [W-1:0]  ra;
    logic [SW-1:0] rs;
    logic [1:0]    rm;
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom_range(0, 15));
      rs = SW'($urandom_range(0, 7));
      rm = 2'($urandom_range(0, 3));
      do_op(ra, rs, rm, model(ra, rs, rm), obs, ex);
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL rand[%0d] a=%b sh=%0d m=%0d got %s want %s", i, ra, rs, rm, fmt(obs),
                 fmt(ex));
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_lsl();
    test_right_shifts();
    test_rotate_and_zero();
    test_back_pressure();
    test_rst_mid_op();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
